// File: rtl/inst_fetch_responder_if.sv
// Fetch-side and instruction-memory-side signals of the fetch responder.
// The responder takes the slave view. IF and the memory share the master view.
interface inst_fetch_responder_if #(
   parameter int ADDR_W = 32
);
   logic              inst_req_valid;
   logic [ADDR_W-1:0] inst_req_pc;
   logic              inst_req_ack;
   logic              inst_flush;
   logic              inst_valid;
   logic [31:0]       inst_rdata;
   logic              inst_adel;
   logic              mem_arvalid;
   logic [ADDR_W-1:0] mem_araddr;
   logic              mem_arready;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_rready;

   modport slave (
      input  inst_req_valid, inst_req_pc, inst_flush,
      input  mem_arready, mem_rvalid, mem_rdata,
      output inst_req_ack, inst_valid, inst_rdata, inst_adel,
      output mem_arvalid, mem_araddr, mem_rready
   );

   modport master (
      output inst_req_valid, inst_req_pc, inst_flush,
      output mem_arready, mem_rvalid, mem_rdata,
      input  inst_req_ack, inst_valid, inst_rdata, inst_adel,
      input  mem_arvalid, mem_araddr, mem_rready
   );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: one outstanding fetch, alignment check,
// one-entry last-fetch buffer and discard of flushed fetches.
module inst_fetch_responder #(
   parameter int ADDR_W     = 32,
   parameter bit HIT_BUF_EN = 1'b1
) (
   input logic                   clk,
   input logic                   resetn,
   inst_fetch_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic              discard_q;
   logic              buf_valid_q;
   logic [ADDR_W-1:0] buf_tag_q;
   logic [31:0]       buf_data_q;
   logic [31:0]       rdata_q;
   logic              adel_q;

   logic req_ack;
   logic misaligned;
   logic buf_hit;
   logic discard_now;
   logic mem_ret;
   logic resp_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // A flush in the current cycle counts as discarding, so a flush that
   // coincides with the data return or the response takes effect at once.
   always_comb begin
      state_d     = state_q;
      req_ack     = 1'b0;
      mem_ret     = 1'b0;
      resp_valid  = 1'b0;
      misaligned  = (bus.inst_req_pc[1:0] != 2'b00);
      buf_hit     = HIT_BUF_EN && buf_valid_q && (buf_tag_q == bus.inst_req_pc);
      discard_now = discard_q | bus.inst_flush;
      case (state_q)
         IDLE: begin
            if (bus.inst_req_valid) begin
               req_ack = 1'b1;
               state_d = (misaligned || buf_hit) ? RESP : AR;
            end
         end
         AR: begin
            if (bus.mem_arready) state_d = R;
         end
         R: begin
            if (bus.mem_rvalid) begin
               mem_ret = 1'b1;
               state_d = discard_now ? IDLE : RESP;
            end
         end
         RESP: begin
            resp_valid = !discard_now;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q        <= '0;
         discard_q   <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
         rdata_q     <= '0;
         adel_q      <= 1'b0;
      end else begin
         if (req_ack) begin
            pc_q <= bus.inst_req_pc;
            if (misaligned) begin
               rdata_q <= '0;
               adel_q  <= 1'b1;
            end else if (buf_hit) begin
               rdata_q <= buf_data_q;
               adel_q  <= 1'b0;
            end
         end
         if (mem_ret && !discard_now) begin
            rdata_q     <= bus.mem_rdata;
            adel_q      <= 1'b0;
            buf_valid_q <= 1'b1;
            buf_tag_q   <= pc_q;
            buf_data_q  <= bus.mem_rdata;
         end
         if (bus.inst_flush) buf_valid_q <= 1'b0;
         if (state_d == IDLE)     discard_q <= 1'b0;
         else if (bus.inst_flush) discard_q <= 1'b1;
      end
   end

   // Combinational outputs are gated so they drop the moment reset asserts.
   assign bus.inst_req_ack = resetn & req_ack;
   assign bus.inst_valid   = resetn & resp_valid;
   assign bus.inst_rdata   = rdata_q;
   assign bus.inst_adel    = adel_q;
   assign bus.mem_arvalid  = resetn & (state_q == AR);
   assign bus.mem_araddr   = resetn ? {pc_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus.mem_rready   = resetn & (state_q == R);

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Randomized self-checking bench for inst_fetch_responder against a
// transaction-level model of the fetch buffer and response latency.
module tb_inst_fetch_responder;

   logic clk;
   logic resetn;
   int   n_checks = 0;
   int   n_errors = 0;

   bit          m_buf_valid;
   logic [31:0] m_buf_tag;
   logic [31:0] m_buf_data;

   logic [31:0] pc_tab [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h380, 32'h382, 32'h101, 32'h40};

   inst_fetch_responder_if #(.ADDR_W(32)) bus ();
   inst_fetch_responder_if #(.ADDR_W(32)) bus_nb ();

   inst_fetch_responder #(.ADDR_W(32), .HIT_BUF_EN(1'b1)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   inst_fetch_responder #(.ADDR_W(32), .HIT_BUF_EN(1'b0)) dut_nb (
      .clk(clk), .resetn(resetn), .bus(bus_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h3C1D8000;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ a;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_ack"},     32'(bus.inst_req_ack), 32'h0);
      check_output({tag, "_valid"},   32'(bus.inst_valid),   32'h0);
      check_output({tag, "_rdata"},   bus.inst_rdata,        32'h0);
      check_output({tag, "_adel"},    32'(bus.inst_adel),    32'h0);
      check_output({tag, "_arvalid"}, 32'(bus.mem_arvalid),  32'h0);
      check_output({tag, "_araddr"},  bus.mem_araddr,        32'h0);
      check_output({tag, "_rready"},  32'(bus.mem_rready),   32'h0);
   endtask

   // flush_sel: -1 no flush, -2 random cycle within the fetch, else that cycle
   task automatic apply_stimulus(input logic [31:0] pc, input int ar_wait, input int r_wait, input int flush_sel);
      logic [31:0] word_addr, exp_data, ar_addr, v_data;
      bit          exp_mem, exp_adel, discard;
      logic        v_adel;
      int          exp_lat, flush_at, waited, ar_seen, r_seen, addr_bad, v_cnt, v_cyc;
      word_addr = {pc[31:2], 2'b00};
      exp_adel  = (pc[1:0] != 2'b00);
      exp_mem   = !exp_adel && !(m_buf_valid && m_buf_tag == pc);
      exp_data  = exp_adel ? 32'h0 : (exp_mem ? mem_word(word_addr) : m_buf_data);
      exp_lat   = exp_mem ? 3 + ar_wait + r_wait : 1;
      flush_at  = (flush_sel == -2) ? int'($urandom_range(0, exp_lat)) : flush_sel;
      discard   = (flush_at >= 0);
      waited = 0; ar_seen = 0; r_seen = 0; addr_bad = 0; v_cnt = 0; v_cyc = -1;
      ar_addr = 32'hFFFFFFFF; v_data = 32'h0; v_adel = 1'b0;

      forever begin
         @(negedge clk);
         bus.inst_req_valid = 1'b1;
         bus.inst_req_pc    = pc;
         bus.inst_flush     = (flush_at == 0);
         bus.mem_arready    = 1'b0;
         bus.mem_rvalid     = 1'b0;
         bus.mem_rdata      = 32'hDEADBEEF;
         #1;
         if (bus.inst_req_ack || waited == 20) break;
         waited++;
      end
      check_output("ack_wait", 32'(waited), 32'h0);
      if (!bus.inst_req_ack) begin
         bus.inst_req_valid = 1'b0;
         return;
      end
      if (bus.inst_valid) v_cnt++;
      if (bus.mem_arvalid) ar_seen++;

      for (int c = 1; c <= exp_lat; c++) begin
         @(negedge clk);
         bus.inst_req_valid = 1'b0;
         bus.inst_req_pc    = $urandom;
         bus.inst_flush     = (c == flush_at);
         bus.mem_arready    = bus.mem_arvalid && (ar_seen == ar_wait);
         bus.mem_rvalid     = bus.mem_rready && (r_seen == r_wait);
         bus.mem_rdata      = bus.mem_rvalid ? mem_word(ar_addr) : 32'hDEADBEEF;
         #1;
         if (bus.mem_arvalid) begin
            if (bus.mem_araddr != word_addr) addr_bad++;
            if (bus.mem_arready) ar_addr = bus.mem_araddr;
            ar_seen++;
         end
         if (bus.mem_rready) r_seen++;
         if (bus.inst_valid) begin
            v_cnt++;
            if (v_cyc < 0) begin
               v_cyc  = c;
               v_data = bus.inst_rdata;
               v_adel = bus.inst_adel;
            end
         end
      end

      check_output("arvalid_cycles", 32'(ar_seen), exp_mem ? 32'(ar_wait + 1) : 32'h0);
      check_output("rready_cycles",  32'(r_seen),  exp_mem ? 32'(r_wait + 1)  : 32'h0);
      if (exp_mem) check_output("araddr_bad", 32'(addr_bad), 32'h0);
      check_output("valid_count", 32'(v_cnt), discard ? 32'h0 : 32'h1);
      if (!discard) begin
         check_output("valid_cycle", 32'(v_cyc), 32'(exp_lat));
         check_output("rdata", v_data, exp_data);
         check_output("adel", 32'(v_adel), 32'(exp_adel));
      end

      if (discard) m_buf_valid = 1'b0;
      else if (exp_mem) begin
         m_buf_valid = 1'b1;
         m_buf_tag   = pc;
         m_buf_data  = exp_data;
      end
   endtask

   // The buffer-less instance sits on a zero-wait memory; every aligned fetch must reach it.
   task automatic nb_fetch(input logic [31:0] pc);
      int          ack_cyc, v_cyc, arv;
      bit          acked;
      logic [31:0] v_data;
      ack_cyc = -1; v_cyc = -1; arv = 0; acked = 1'b0; v_data = 32'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus_nb.inst_req_valid = !acked;
         bus_nb.inst_req_pc    = pc;
         bus_nb.inst_flush     = 1'b0;
         bus_nb.mem_arready    = 1'b1;
         bus_nb.mem_rvalid     = 1'b1;
         bus_nb.mem_rdata      = mem_word(bus_nb.mem_araddr);
         #1;
         if (bus_nb.mem_arvalid) arv++;
         if (bus_nb.inst_valid && v_cyc < 0) begin
            v_cyc  = c;
            v_data = bus_nb.inst_rdata;
         end
         if (bus_nb.inst_req_ack && !acked) begin
            acked   = 1'b1;
            ack_cyc = c;
         end
      end
      bus_nb.inst_req_valid = 1'b0;
      check_output("nb_ack_cycle", 32'(ack_cyc), 32'h0);
      check_output("nb_mem_access", 32'(arv), 32'h1);
      check_output("nb_latency", 32'(v_cyc - ack_cyc), 32'h3);
      check_output("nb_rdata", v_data, mem_word({pc[31:2], 2'b00}));
   endtask

   initial begin
      resetn = 1'b0;
      bus.inst_req_valid = 1'b1;
      bus.inst_req_pc    = 32'h0;
      bus.inst_flush     = 1'b0;
      bus.mem_arready    = 1'b0;
      bus.mem_rvalid     = 1'b0;
      bus.mem_rdata      = 32'h0;
      bus_nb.inst_req_valid = 1'b0;
      bus_nb.inst_req_pc    = 32'h0;
      bus_nb.inst_flush     = 1'b0;
      bus_nb.mem_arready    = 1'b0;
      bus_nb.mem_rvalid     = 1'b0;
      bus_nb.mem_rdata      = 32'h0;
      m_buf_valid = 1'b0;
      m_buf_tag   = 32'h0;
      m_buf_data  = 32'h0;

      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      resetn = 1'b1;
      bus.inst_req_valid = 1'b0;

      $display("[TB] miss, hit and misaligned fetches");
      apply_stimulus(32'h0, 0, 0, -1);
      apply_stimulus(32'h0, 0, 0, -1);
      apply_stimulus(32'h382, 0, 0, -1);
      nb_fetch(32'h0);
      nb_fetch(32'h0);

      $display("[TB] flush during address phase with stalled memory");
      apply_stimulus(32'h100, 3, 2, 2);
      apply_stimulus(32'h380, 0, 0, -1);

      $display("[TB] back-to-back fetches with random stalls");
      apply_stimulus(32'h4, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      apply_stimulus(32'h8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      apply_stimulus(32'hC, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);

      $display("[TB] reset while waiting for read data");
      @(negedge clk);
      bus.inst_req_valid = 1'b1;
      bus.inst_req_pc    = 32'h44;
      bus.inst_flush     = 1'b0;
      bus.mem_arready    = 1'b0;
      bus.mem_rvalid     = 1'b0;
      #1;
      check_output("rst_seq_ack", 32'(bus.inst_req_ack), 32'h1);
      @(negedge clk);
      bus.inst_req_valid = 1'b0;
      bus.mem_arready    = 1'b1;
      #1;
      check_output("rst_seq_arvalid", 32'(bus.mem_arvalid), 32'h1);
      @(negedge clk);
      bus.mem_arready = 1'b0;
      #1;
      check_output("rst_seq_rready", 32'(bus.mem_rready), 32'h1);
      @(negedge clk);
      resetn = 1'b0;
      bus.inst_req_valid = 1'b1;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      resetn = 1'b1;
      bus.inst_req_valid = 1'b0;
      m_buf_valid = 1'b0;
      apply_stimulus(32'h380, 0, 0, -1);

      $display("[TB] randomized fetch mix");
      for (int i = 0; i < 40; i++) begin
         apply_stimulus(pc_tab[$urandom_range(0, 7)],
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        ($urandom_range(0, 4) == 0) ? -2 : -1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Instruction-side responder for the IF stage's fetch request handshake. It accepts a fetch PC from IF (valid/ack), reads the instruction word over the instruction memory read channel (address/data valid-ready), and returns it to IF with a one-cycle valid pulse. It also provides:
- alignment-error detection;
- a one-entry last-fetch buffer, so that a stalled re-fetch of the same PC completes without a memory access;
- discard of in-flight fetches on pipeline flush (exception, interrupt, ERET, branch mispredict).

## Interface
- `ADDR_W`, 32, fetch and memory address width
- `HIT_BUF_EN`, 1, enables the one-entry last-fetch buffer; 0 forces every aligned fetch to memory
- `clk`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `inst_req_valid`  in  1  fetch request from IF; held until acked
- `inst_req_pc`  in  ADDR_W  fetch PC, sampled in the ack cycle
- `inst_req_ack`  out  1  request accepted this cycle
- `inst_flush`  in  1  discard any accepted-but-unreturned fetch
- `inst_valid`  out  1  one-cycle pulse; `inst_rdata`/`inst_adel` valid
- `inst_rdata`  out  32  fetched instruction; 0 when `inst_adel`
- `inst_adel`  out  1  fetch PC misaligned (`pc[1:0]!=0`)
- `mem_arvalid`  out  1  memory read address valid
- `mem_araddr`  out  ADDR_W  word address, `{pc[ADDR_W-1:2],2'b00}`
- `mem_arready`  in  1  memory accepts address
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data
- `mem_rready`  out  1  responder accepts read data

## Operation
- States: IDLE, AR, R, RESP.
- IDLE:
  - `inst_req_ack = inst_req_valid` (combinational); on ack, capture the PC.
  - Misaligned PC, or buffer hit (`HIT_BUF_EN`, buffer valid, tag == PC): go to RESP.
  - Otherwise: go to AR.
- AR:
  - `mem_arvalid=1`, `mem_araddr` stable.
  - On `mem_arready`: go to R.
  - `mem_arvalid` never drops before `mem_arready`.
- R:
  - `mem_rready=1`.
  - On `mem_rvalid`: capture `mem_rdata` and go to RESP, or to IDLE if discarding.
- RESP:
  - `inst_valid=1` for exactly one cycle, unless discarding; then go to IDLE.
  - `inst_rdata` and `inst_adel` hold until the next RESP.
- Misaligned fetch: no memory access; `inst_adel=1`, `inst_rdata=0`.
- Buffer:
  - Loaded with (PC, data) on every non-discarded memory return.
  - Invalidated by `inst_flush` and by reset.
  - Misaligned PCs are never stored.
- Flush: `inst_flush` in any cycle where a fetch is accepted or in flight (including the ack cycle) sets a discard flag for that fetch.
  - In AR: the address handshake still completes; the data is still drained in R.
  - No `inst_valid` for a discarded fetch.
  - The discard flag clears on return to IDLE.
- `inst_flush` in IDLE with no ack has no effect besides buffer invalidation.
- No new ack while not in IDLE. At most one fetch is outstanding.

## Timing
- Reset (async, immediate): state IDLE; all of the following are 0 and deassert combinationally during reset:
  - `inst_req_ack`, `inst_valid`, `inst_rdata`, `inst_adel`
  - `mem_arvalid`, `mem_araddr`, `mem_rready`
  - buffer valid, discard flag
- Reset mid-operation abandons any bus transaction; memory-side recovery is the memory's responsibility.
- Miss latency, ack at cycle 0 with zero-wait memory (`arready`, `rvalid` high on first assertion):
  - AR at cycle 1
  - R at cycle 2
  - `inst_valid` at cycle 3
- Each memory wait cycle adds one cycle.
- Hit or misaligned: ack at cycle 0, `inst_valid` at cycle 1.
- Next ack no earlier than the cycle after the `inst_valid` pulse (IDLE re-entry). Throughput is 1 fetch per 2 cycles on hit, per 4 cycles on zero-wait miss.
- Flush and `mem_rvalid` in the same cycle: data is discarded and the buffer is not loaded.
- Flush in the RESP cycle suppresses that `inst_valid`.

## Test plan
- Reset, then request PC `0x00000000` with memory returning `0x3C1D8000` and zero wait: ack at cycle 0, `mem_araddr=0`, `inst_valid` at cycle 3 with `inst_rdata=0x3C1D8000`, `inst_adel=0`.
- Re-request `0x00000000` immediately: `inst_valid` one cycle after ack, no `mem_arvalid` asserted; with `HIT_BUF_EN=0`, full memory access instead.
- Request PC `0x00000382`: `inst_valid` one cycle after ack, `inst_adel=1`, `inst_rdata=0`, no memory access.
- Request PC `0x00000100` with `mem_arready` delayed 3 cycles and `mem_rvalid` delayed 2 cycles; pulse `inst_flush` during AR: `mem_arvalid` held until arready, data drained, no `inst_valid`. The next request to `0x00000380` returns its own data.
- Assert `resetn=0` while in R: all outputs 0 in the same cycle; after release, the first request is acked in IDLE.
- Back-to-back requests at `0x00000004`, `0x00000008`, `0x0000000C` with random memory stalls: returned data matches the memory model in order, and `inst_valid` never pulses twice per ack.
